voice_allocator: RTL and testbench

Polyphonic voice scheduler that converts a stream of note-on/note-off events into per-voice `gate` and `tone_freq` drives for a bank of `voice` instances. Free voices are assigned lowest-index-first; when all are busy, the least-recently-assigned voice is stolen. A stolen voice is given a forced gate-low gap so that its ADSR retriggers. The block sits between an event source (MIDI/UART front end or sequencer) and the voice bank. It runs on the tone-generator clock.

---
 rtl/voice_allocator_pkg.sv | 43 ++++
 rtl/voice_allocator_note_to_freq.sv | 36 +++
 rtl/voice_allocator.sv | 148 ++++++++++++++
 tb/tb_voice_allocator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: note width, FSM states,
// target kinds and the top-octave frequency ROM.
package voice_allocator_pkg;

  localparam int NOTE_BITS = 7;
  localparam int FREQ_BITS = 16;
  localparam int ROM_BITS  = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    T_FREE,
    T_RETRIG,
    T_STEAL
  } tgt_kind_e;

  // round(2^24 * f / 1 MHz) for C7..B7; lower octaves are right shifts of these.
  function automatic logic [ROM_BITS-1:0] freq_rom(input logic [3:0] idx);
    logic [ROM_BITS-1:0] v;
    case (idx)
      4'd0:    v = 17'd35115;
      4'd1:    v = 17'd37203;
      4'd2:    v = 17'd39415;
      4'd3:    v = 17'd41759;
      4'd4:    v = 17'd44242;
      4'd5:    v = 17'd46873;
      4'd6:    v = 17'd49660;
      4'd7:    v = 17'd52613;
      4'd8:    v = 17'd55741;
      4'd9:    v = 17'd59056;
      4'd10:   v = 17'd62567;
      4'd11:   v = 17'd66288;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/voice_allocator_note_to_freq.sv
// MIDI note to tone_freq increment: octave split, ROM lookup, shift and
// saturate, with the result registered (one cycle of latency).
module note_to_freq
  import voice_allocator_pkg::*;
(
  input  logic                 clk,
  input  logic [NOTE_BITS-1:0] note_i,
  output logic [FREQ_BITS-1:0] freq_o
);

  logic [3:0]          oct;
  logic [3:0]          idx;
  logic [ROM_BITS-1:0] rom_val;
  logic [ROM_BITS-1:0] shifted;
  logic [FREQ_BITS-1:0] freq_d;
  logic [FREQ_BITS-1:0] freq_q;

  always_comb begin
    oct     = 4'(note_i / 7'd12);
    idx     = 4'(note_i % 7'd12);
    rom_val = freq_rom(idx);
    shifted = '0;
    freq_d  = 16'hFFFF;
    if (oct <= 4'd8) begin
      shifted = rom_val >> (4'd8 - oct);
      if (shifted <= 17'h0FFFF) freq_d = shifted[FREQ_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    freq_q <= freq_d;
  end

  assign freq_o = freq_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: lowest-free allocation, LRU stealing and a
// forced gate-low gap on steal/retrigger so the voice ADSR restarts.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int RETRIG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [NOTE_BITS-1:0]    ev_note,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [16*NUM_VOICES-1:0] voice_freq,
  output logic                    voice_stolen
);

  localparam int AW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(RETRIG_CYCLES) + 1;

  state_e                 state_q, state_d;
  tgt_kind_e              kind_q;
  logic [AW-1:0]          tgt_q;
  logic                   hit_q;
  logic                   ev_on_q;
  logic [NOTE_BITS-1:0]   ev_note_q;
  logic [CW-1:0]          cnt_q;
  logic                   stolen_q;
  logic [NUM_VOICES-1:0]  gate_q;
  logic [NOTE_BITS-1:0]   note_q [NUM_VOICES];
  logic [AW-1:0]          age_q  [NUM_VOICES];
  logic [FREQ_BITS-1:0]   freq_q [NUM_VOICES];
  logic [FREQ_BITS-1:0]   lut_freq;

  logic                   match_hit, free_hit;
  logic [AW-1:0]          match_idx, free_idx, oldest_idx;

  note_to_freq u_note_to_freq (
    .clk    (clk),
    .note_i (ev_note_q),
    .freq_o (lut_freq)
  );

  // Descending scan so the lowest matching index wins.
  always_comb begin
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i] == ev_note)) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
      if (!gate_q[i]) begin
        free_hit = 1'b1;
        free_idx = AW'(i);
      end
      if (age_q[i] == AW'(NUM_VOICES - 1)) oldest_idx = AW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) state_d = ev_note_on ? S_LOOKUP : S_APPLY;
      end
      S_LOOKUP: state_d = S_APPLY;
      S_APPLY:  state_d = (ev_on_q && (kind_q != T_FREE)) ? S_GAP : S_IDLE;
      S_GAP:    if (cnt_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q    <= T_FREE;
      tgt_q     <= '0;
      hit_q     <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      cnt_q     <= '0;
      stolen_q  <= 1'b0;
      gate_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= AW'(i);
        freq_q[i] <= '0;
      end
    end else begin
      stolen_q <= 1'b0;
      case (state_q)
        S_IDLE: if (ev_valid) begin
          ev_on_q   <= ev_note_on;
          ev_note_q <= ev_note;
          hit_q     <= match_hit;
          if (!ev_note_on || match_hit) begin
            tgt_q  <= match_idx;
            kind_q <= T_RETRIG;
          end else if (free_hit) begin
            tgt_q  <= free_idx;
            kind_q <= T_FREE;
          end else begin
            tgt_q  <= oldest_idx;
            kind_q <= T_STEAL;
          end
        end
        S_APPLY: if (ev_on_q) begin
          freq_q[tgt_q] <= lut_freq;
          note_q[tgt_q] <= ev_note_q;
          gate_q[tgt_q] <= (kind_q == T_FREE);
          stolen_q      <= (kind_q == T_STEAL);
          cnt_q         <= CW'(RETRIG_CYCLES - 1);
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (AW'(i) == tgt_q)              age_q[i] <= '0;
            else if (age_q[i] < age_q[tgt_q]) age_q[i] <= age_q[i] + 1'b1;
          end
        end else if (hit_q) begin
          gate_q[tgt_q] <= 1'b0;
        end
        S_GAP: begin
          if (cnt_q == '0) gate_q[tgt_q] <= 1'b1;
          else             cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) voice_freq[16*i +: 16] = freq_q[i];
  end

  assign voice_gate   = gate_q;
  assign voice_stolen = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a recency-queue voice model with
// frequencies computed from equal-temperament pitch, checked every cycle.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int RC = 64;
  localparam int K_FREE = 0, K_RETRIG = 1, K_STEAL = 2, K_OFF = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_note_on = 1'b0;
  logic [6:0]        ev_note = '0;
  logic [NV-1:0]     voice_gate;
  logic [16*NV-1:0]  voice_freq;
  logic              voice_stolen;

  int checks = 0;
  int errors = 0;

  bit m_gate [NV];
  int m_note [NV];
  int m_freq [NV];
  int lru [$];

  voice_allocator #(.NUM_VOICES(NV), .RETRIG_CYCLES(RC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_note      (ev_note),
    .voice_gate   (voice_gate),
    .voice_freq   (voice_freq),
    .voice_stolen (voice_stolen)
  );

  always #5 clk = ~clk;

  function automatic int ref_freq(input int note);
    int o, rom;
    real f;
    o = note / 12;
    if (o > 8) return 65535;
    f = 440.0 * $pow(2.0, real'(96 + note % 12 - 69) / 12.0);
    rom = $rtoi(f * 16777216.0 / 1.0e6 + 0.5);
    rom = rom >> (8 - o);
    return (rom > 65535) ? 65535 : rom;
  endfunction

  function automatic logic [NV-1:0] pack_gate();
    logic [NV-1:0] g;
    for (int i = 0; i < NV; i++) g[i] = m_gate[i];
    return g;
  endfunction

  function automatic logic [16*NV-1:0] pack_freq();
    logic [16*NV-1:0] f;
    for (int i = 0; i < NV; i++) f[16*i +: 16] = 16'(m_freq[i]);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = 0;
      m_freq[i] = 0;
    end
    lru = {};
    for (int i = NV - 1; i >= 0; i--) lru.push_back(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one event and check gates, freqs, ready and stolen on every cycle
  // until the block is ready again.
  task automatic send(input bit on, input int note, output int tgt);
    int kind, lat;
    logic [NV-1:0] gb, ga, gg, eg;
    logic [16*NV-1:0] fb, fa, ef;
    tgt = -1;
    gb = pack_gate();
    fb = pack_freq();
    if (on) begin
      for (int i = NV - 1; i >= 0; i--) if (m_gate[i] && m_note[i] == note) tgt = i;
      if (tgt >= 0) kind = K_RETRIG;
      else begin
        for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) tgt = i;
        if (tgt >= 0) kind = K_FREE;
        else begin
          tgt = lru[0];
          kind = K_STEAL;
        end
      end
      m_note[tgt] = note;
      m_freq[tgt] = ref_freq(note);
      m_gate[tgt] = 1'b1;
      for (int k = 0; k < lru.size(); k++) if (lru[k] == tgt) begin
        lru.delete(k);
        break;
      end
      lru.push_back(tgt);
      lat = (kind == K_FREE) ? 2 : 2 + RC;
    end else begin
      kind = K_OFF;
      for (int i = NV - 1; i >= 0; i--) if (m_gate[i] && m_note[i] == note) tgt = i;
      if (tgt >= 0) m_gate[tgt] = 1'b0;
      lat = 1;
    end
    ga = pack_gate();
    fa = pack_freq();
    gg = ga;
    if (tgt >= 0) gg[tgt] = 1'b0;

    @(negedge clk);
    ev_valid = 1'b1;
    ev_note_on = on;
    ev_note = 7'(note);
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_issue note=%0d got %b want 1", note, ev_ready);
    end
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (!on) eg = (c >= 1) ? ga : gb;
      else if (c < 2) eg = gb;
      else if (kind == K_FREE || c == lat) eg = ga;
      else eg = gg;
      ef = (on && c >= 2) ? fa : fb;
      checks++;
      if (voice_gate !== eg) begin
        errors++;
        $display("FAIL gate note=%0d on=%0d cyc=%0d got %b want %b", note, on, c, voice_gate, eg);
      end
      checks++;
      if (voice_freq !== ef) begin
        errors++;
        $display("FAIL freq note=%0d on=%0d cyc=%0d got %h want %h", note, on, c, voice_freq, ef);
      end
      checks++;
      if (ev_ready !== (c == lat)) begin
        errors++;
        $display("FAIL ready note=%0d on=%0d cyc=%0d got %b want %b", note, on, c, ev_ready, c == lat);
      end
      checks++;
      if (voice_stolen !== (kind == K_STEAL && c == 2)) begin
        errors++;
        $display("FAIL stolen note=%0d cyc=%0d got %b want %b", note, c, voice_stolen,
                 kind == K_STEAL && c == 2);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (voice_gate !== '0 || voice_freq !== '0 || voice_stolen !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got gate=%b freq=%h stolen=%b want 0", voice_gate, voice_freq, voice_stolen);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ev_ready);
    end
  endtask

  task automatic test_first_note();
    int t;
    send(1'b1, 60, t);
    checks++;
    if (voice_freq[15:0] !== 16'd4389 || voice_gate[0] !== 1'b1) begin
      errors++;
      $display("FAIL note60 got freq=%0d gate=%b want 4389 1", voice_freq[15:0], voice_gate[0]);
    end
  endtask

  task automatic test_fill_and_steal();
    int t;
    send(1'b1, 64, t);
    send(1'b1, 67, t);
    send(1'b1, 72, t);
    send(1'b1, 76, t);
    checks++;
    if (voice_freq[15:0] !== 16'd11060 || voice_gate !== 4'b1111) begin
      errors++;
      $display("FAIL steal76 got freq0=%0d gate=%b want 11060 1111", voice_freq[15:0], voice_gate);
    end
  endtask

  task automatic test_retrigger();
    int t;
    send(1'b1, 64, t);
  endtask

  task automatic test_note_off();
    int t;
    send(1'b0, 67, t);
    send(1'b0, 50, t);
  endtask

  task automatic test_boundary();
    int t;
    int notes [4] = '{0, 106, 107, 127};
    int want  [4] = '{137, 62567, 65535, 65535};
    for (int k = 0; k < 4; k++) begin
      send(1'b1, notes[k], t);
      checks++;
      if (voice_freq[16*t +: 16] !== 16'(want[k])) begin
        errors++;
        $display("FAIL boundary note=%0d got %0d want %0d", notes[k], voice_freq[16*t +: 16], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int t;
    do_reset();
    for (int k = 0; k < 50; k++)
      send($urandom_range(0, 99) < 60, int'($urandom_range(58, 66)), t);
  endtask

  task automatic test_reset_in_gap();
    int t;
    do_reset();
    for (int k = 0; k < NV; k++) send(1'b1, 40 + k, t);
    @(negedge clk);
    ev_valid = 1'b1;
    ev_note_on = 1'b1;
    ev_note = 7'd90;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (voice_gate !== '0 || voice_freq !== '0 || voice_stolen !== 1'b0) begin
      errors++;
      $display("FAIL gap_reset got gate=%b freq=%h stolen=%b want 0", voice_gate, voice_freq, voice_stolen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_reset_ready got %b want 1", ev_ready);
    end
    repeat (RC + 10) @(posedge clk);
    #1;
    checks++;
    if (voice_gate !== '0) begin
      errors++;
      $display("FAIL gap_no_rise got %b want 0", voice_gate);
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_fill_and_steal();
    test_retrigger();
    test_note_off();
    test_boundary();
    test_back_to_back_random();
    test_reset_in_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
